// File: rtl/morse_player.sv
// Buffered Morse keyer: queued characters (symbol pattern + length) are played
// back-to-back as registered tone_on/is_dash with standard unit timing.
module morse_player #(
  parameter int DEPTH          = 8,
  parameter int MAX_SYM        = 6,
  parameter int UNIT_CYCLES    = 2500000,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  localparam int LW = $clog2(MAX_SYM + 1),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [MAX_SYM-1:0] wr_code,
  input  logic [LW-1:0]      wr_len,
  output logic               wr_ready,
  input  logic               abort,
  output logic               tone_on,
  output logic               is_dash,
  output logic               busy,
  output logic [CW-1:0]      level,
  output logic               char_done,
  output logic               overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int UCW = $clog2(UNIT_CYCLES);
  localparam int MAX_UNITS =
    (DASH_UNITS > CHAR_GAP_UNITS) ?
      ((DASH_UNITS > WORD_GAP_UNITS) ? DASH_UNITS : WORD_GAP_UNITS) :
      ((CHAR_GAP_UNITS > WORD_GAP_UNITS) ? CHAR_GAP_UNITS : WORD_GAP_UNITS);
  localparam int MUW = $clog2(MAX_UNITS + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MARK  = 3'd1;
  localparam logic [2:0] SPACE = 3'd2;
  localparam logic [2:0] CGAP  = 3'd3;
  localparam logic [2:0] WGAP  = 3'd4;

  logic [MAX_SYM-1:0] mem_code [DEPTH];
  logic [LW-1:0]      mem_len  [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;

  logic [2:0]         state, state_nx;
  logic [MAX_SYM-1:0] code, code_nx;
  logic [LW-1:0]      len, len_nx, sym_idx, sym_idx_nx;
  logic [UCW-1:0]     unit_cnt;
  logic [MUW-1:0]     mult_cnt, mult_last;
  logic [LW-1:0]      len_clamped;
  logic               full, push, pop, timer_done, cur_dash, dash_nx;

  assign full        = (level == CW'(DEPTH));
  assign push        = wr_en && !full && !abort;
  assign pop         = (state == IDLE) && (level != '0) && !abort;
  assign len_clamped = (wr_len > LW'(MAX_SYM)) ? LW'(MAX_SYM) : wr_len;
  assign busy        = (state != IDLE);
  assign cur_dash    = |(code & (MAX_SYM'(1) << sym_idx));
  assign dash_nx     = |(code_nx & (MAX_SYM'(1) << sym_idx_nx));

  // Duration of the current state is (mult_last+1) units of UNIT_CYCLES each.
  always_comb begin
    mult_last = '0;
    case (state)
      MARK:    mult_last = cur_dash ? MUW'(DASH_UNITS - 1) : '0;
      CGAP:    mult_last = MUW'(CHAR_GAP_UNITS - 1);
      WGAP:    mult_last = MUW'(WORD_GAP_UNITS - 1);
      default: mult_last = '0;
    endcase
  end

  assign timer_done = (unit_cnt == UCW'(UNIT_CYCLES - 1)) && (mult_cnt == mult_last);

  always_comb begin
    state_nx   = state;
    code_nx    = code;
    len_nx     = len;
    sym_idx_nx = sym_idx;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (pop) begin
          code_nx    = mem_code[rd_ptr];
          len_nx     = mem_len[rd_ptr];
          sym_idx_nx = '0;
          state_nx   = (mem_len[rd_ptr] != '0) ? MARK : WGAP;
        end
        MARK: if (timer_done) begin
          sym_idx_nx = sym_idx + 1'b1;
          state_nx   = (sym_idx_nx < len) ? SPACE : CGAP;
        end
        SPACE: if (timer_done) state_nx = MARK;
        CGAP, WGAP: if (timer_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state so the first tone follows the pop by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      code      <= '0;
      len       <= '0;
      sym_idx   <= '0;
      unit_cnt  <= '0;
      mult_cnt  <= '0;
      tone_on   <= 1'b0;
      is_dash   <= 1'b0;
      char_done <= 1'b0;
    end else begin
      state     <= state_nx;
      code      <= code_nx;
      len       <= len_nx;
      sym_idx   <= sym_idx_nx;
      tone_on   <= (state_nx == MARK);
      is_dash   <= (state_nx == MARK) && dash_nx;
      char_done <= !abort && ((state == CGAP) || (state == WGAP)) && timer_done;
      if (abort || (state_nx != state)) begin
        unit_cnt <= '0;
        mult_cnt <= '0;
      end else if (state != IDLE) begin
        if (unit_cnt == UCW'(UNIT_CYCLES - 1)) begin
          unit_cnt <= '0;
          mult_cnt <= mult_cnt + 1'b1;
        end else begin
          unit_cnt <= unit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr] <= wr_code;
      mem_len[wr_ptr]  <= len_clamped;
    end
  end

  // A pop never frees a slot for a push in the same cycle: push is gated on the registered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b1;
      overflow <= 1'b0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10: begin
          level    <= level + 1'b1;
          wr_ready <= (level != CW'(DEPTH - 1));
        end
        2'b01: begin
          level    <= level - 1'b1;
          wr_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with UNIT_CYCLES=4: table-driven single characters
// plus hand-written back-to-back, FIFO-full, abort and reset sequences.
module tb_morse_player;
  localparam int UNIT = 4;

  logic       clk = 1'b0;
  logic       reset, wr_en, abort;
  logic [5:0] wr_code;
  logic [2:0] wr_len;
  logic       wr_ready, tone_on, is_dash, busy, char_done, overflow;
  logic [3:0] level;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] code;
    logic [2:0] len;
    int         exp_tone;
    int         exp_busy;
    int         exp_dash;
  } char_vec_t;

  morse_player #(.UNIT_CYCLES(UNIT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_code(wr_code), .wr_len(wr_len),
    .wr_ready(wr_ready), .abort(abort), .tone_on(tone_on), .is_dash(is_dash),
    .busy(busy), .level(level), .char_done(char_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drives the inputs for exactly one clock edge, then returns them to idle.
  task automatic applyStimulus(input logic en, input logic [5:0] code, input logic [2:0] len,
                               input logic ab, input logic rst);
    wr_en = en; wr_code = code; wr_len = len; abort = ab; reset = rst;
    @(negedge clk);
    wr_en = 1'b0; wr_code = '0; wr_len = '0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic runChar(input char_vec_t v, input int idx);
    logic exp_t[$];
    logic exp_d[$];
    int   nsym;
    int   n_tone = 0;
    int   n_busy = 0;
    int   n_dash = 0;
    nsym = (v.len > 3'd6) ? 6 : int'(v.len);
    for (int s = 0; s < nsym; s++) begin
      int dur;
      dur = v.code[s] ? 3 * UNIT : UNIT;
      repeat (dur) begin exp_t.push_back(1'b1); exp_d.push_back(v.code[s]); end
      if (s < nsym - 1) repeat (UNIT) begin exp_t.push_back(1'b0); exp_d.push_back(1'b0); end
    end
    repeat ((nsym == 0 ? 7 : 3) * UNIT) begin exp_t.push_back(1'b0); exp_d.push_back(1'b0); end

    applyStimulus(1'b1, v.code, v.len, 1'b0, 1'b0);
    checkOutput($sformatf("char%0d level_after_push", idx), level, 1);
    @(negedge clk);
    for (int i = 0; i < exp_t.size(); i++) begin
      checkOutput($sformatf("char%0d tone_on[%0d]", idx, i), tone_on, exp_t[i]);
      checkOutput($sformatf("char%0d is_dash[%0d]", idx, i), is_dash, exp_d[i]);
      checkOutput($sformatf("char%0d char_done[%0d]", idx, i), char_done, 0);
      n_tone += int'(tone_on);
      n_busy += int'(busy);
      n_dash += int'(tone_on && is_dash);
      @(negedge clk);
    end
    checkOutput($sformatf("char%0d char_done_end", idx), char_done, 1);
    checkOutput($sformatf("char%0d busy_end", idx), busy, 0);
    checkOutput($sformatf("char%0d tone_cycles", idx), n_tone, v.exp_tone);
    checkOutput($sformatf("char%0d busy_cycles", idx), n_busy, v.exp_busy);
    checkOutput($sformatf("char%0d dash_cycles", idx), n_dash, v.exp_dash);
    @(negedge clk);
    checkOutput($sformatf("char%0d char_done_pulse", idx), char_done, 0);
  endtask

  initial begin
    char_vec_t vecs[6];
    logic exp_tone, exp_dash, exp_cd;
    int   gap, pulses, phase;
    logic found;

    // code, len, tone cycles, busy cycles, dash-tone cycles
    vecs[0] = '{6'b000010, 3'd2, 16, 32, 12};  // A
    vecs[1] = '{6'b000000, 3'd1,  4, 16,  0};  // E
    vecs[2] = '{6'b000001, 3'd1, 12, 24, 12};  // T
    vecs[3] = '{6'b000000, 3'd0,  0, 28,  0};  // word space
    vecs[4] = '{6'b101101, 3'd7, 56, 88, 48};  // clamped to 6 symbols
    vecs[5] = '{6'b110101, 3'd5, 44, 72, 36};

    wr_en = 1'b0; wr_code = '0; wr_len = '0; abort = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset tone_on", tone_on, 0);
    checkOutput("reset is_dash", is_dash, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset wr_ready", wr_ready, 1);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset char_done", char_done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) runChar(vecs[i], i);

    // E pushed in cycle 0, T in cycle 1; T pops in E's char_done cycle (18)
    applyStimulus(1'b1, 6'b000000, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b000001, 3'd1, 1'b0, 1'b0);
    gap = 0; pulses = 0; phase = 0;
    for (int c = 2; c <= 44; c++) begin
      exp_tone = ((c >= 2) && (c <= 5)) || ((c >= 19) && (c <= 30));
      exp_dash = (c >= 19) && (c <= 30);
      exp_cd   = (c == 18) || (c == 43);
      checkOutput($sformatf("ET tone_on c%0d", c), tone_on, exp_tone);
      checkOutput($sformatf("ET is_dash c%0d", c), is_dash, exp_dash);
      checkOutput($sformatf("ET char_done c%0d", c), char_done, exp_cd);
      pulses += int'(char_done);
      if (phase == 0 && tone_on) phase = 1;
      else if (phase == 1 && !tone_on) begin phase = 2; gap = 1; end
      else if (phase == 2 && !tone_on) gap++;
      else if (phase == 2 && tone_on) phase = 3;
      @(negedge clk);
    end
    checkOutput("ET silence", gap, 13);
    checkOutput("ET char_done count", pulses, 2);
    checkOutput("ET busy end", busy, 0);

    // FIFO full while a long 'O' plays
    applyStimulus(1'b1, 6'b000111, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("full level start", level, 0);
    checkOutput("full busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("full wr_ready %0d", i), wr_ready, 1);
      applyStimulus(1'b1, 6'b000000, 3'd1, 1'b0, 1'b0);
      checkOutput($sformatf("full level %0d", i), level, i + 1);
    end
    checkOutput("full wr_ready", wr_ready, 0);
    checkOutput("full overflow before", overflow, 0);
    applyStimulus(1'b1, 6'b000000, 3'd1, 1'b0, 1'b0);
    checkOutput("full level after 9th", level, 8);
    checkOutput("full overflow after 9th", overflow, 1);
    checkOutput("full wr_ready after 9th", wr_ready, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (char_done) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("full O char_done seen", found, 1);
    applyStimulus(1'b1, 6'b000001, 3'd1, 1'b0, 1'b0);
    checkOutput("full push during pop dropped", level, 7);
    checkOutput("full wr_ready after pop", wr_ready, 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("flush level", level, 0);
    checkOutput("flush busy", busy, 0);
    checkOutput("flush overflow kept", overflow, 1);

    // abort mid-dash with 3 entries queued, then reset in the same scenario
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(1'b1, 6'b000111, 3'd3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'b000000, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("stop%0d tone before", pass), tone_on, 1);
      checkOutput($sformatf("stop%0d dash before", pass), is_dash, 1);
      checkOutput($sformatf("stop%0d level before", pass), level, 3);
      applyStimulus(1'b1, 6'b000001, 3'd1, (pass == 0), (pass == 1));
      checkOutput($sformatf("stop%0d tone_on", pass), tone_on, 0);
      checkOutput($sformatf("stop%0d is_dash", pass), is_dash, 0);
      checkOutput($sformatf("stop%0d level", pass), level, 0);
      checkOutput($sformatf("stop%0d busy", pass), busy, 0);
      checkOutput($sformatf("stop%0d wr_ready", pass), wr_ready, 1);
      checkOutput($sformatf("stop%0d overflow", pass), overflow, (pass == 0));
      for (int i = 0; i < 20; i++) begin
        checkOutput($sformatf("stop%0d char_done %0d", pass, i), char_done, 0);
        checkOutput($sformatf("stop%0d quiet %0d", pass, i), tone_on, 0);
        @(negedge clk);
      end
      runChar(vecs[1 + pass], 10 + pass);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
